log_reg_feeder: RTL and testbench

Initiator-side sequencer for the `log_reg` inference core.
- Collects feature words from an upstream valid/ready stream into a NUM_FEATURES-wide vector.
- Drives the core's `start`/`features` inputs and waits for `done`.
- Captures `prediction` and returns it, with status, on a downstream valid/ready stream.
- Sits between the host/DMA-side stream fabric and one `log_reg` instance.

---
 rtl/log_reg_pkg.sv | 16 +
 rtl/log_reg_watchdog.sv | 44 ++++
 rtl/log_reg_feeder.sv | 165 ++++++++++++++++
 tb/tb_log_reg_feeder.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/log_reg_pkg.sv
// Shared types and constants for the log_reg feeder and its optional watchdog.
package log_reg_pkg;

  localparam int DATA_W     = 32;
  localparam int ST_SHORT   = 0;
  localparam int ST_TIMEOUT = 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_FIRE = 3'd2,
    S_WAIT = 3'd3,
    S_HOLD = 3'd4
  } feeder_state_t;

endpackage

// File: rtl/log_reg_watchdog.sv
// WAIT-state watchdog for log_reg_feeder; only built when LOG_REG_FEEDER_TIMEOUT_EN is defined.
// expired_o rises in the LIMIT-th counting cycle after a clear.
`ifdef LOG_REG_FEEDER_TIMEOUT_EN
module log_reg_watchdog #(
  parameter int LIMIT = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic count_i,
  output logic expired_o
);

  localparam int CNT_W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear on entry, otherwise count up and saturate at the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (count_i && (cnt_q != CNT_LAST)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = count_i && (cnt_q == CNT_LAST);

endmodule
`endif

// File: rtl/log_reg_feeder.sv
// Initiator-side sequencer for one log_reg core: gathers a feature vector, fires the core, returns its result.
// Optional WAIT watchdog is compiled in with LOG_REG_FEEDER_TIMEOUT_EN.
module log_reg_feeder
  import log_reg_pkg::*;
#(
  parameter int NUM_FEATURES   = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              start,
  output logic [DATA_W-1:0] features [NUM_FEATURES],
  input  logic [DATA_W-1:0] core_prediction,
  input  logic              core_done,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_status,
  output logic [15:0]       vec_count
);

  localparam int IDX_W = $clog2(NUM_FEATURES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FEATURES - 1);

  feeder_state_t     state_q;
  feeder_state_t     state_d;
  logic [IDX_W-1:0]  idx_q;
  logic [IDX_W-1:0]  idx_d;
  logic [DATA_W-1:0] feat_q [NUM_FEATURES];
  logic [DATA_W-1:0] feat_d [NUM_FEATURES];
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] data_d;
  logic [1:0]        status_q;
  logic [1:0]        status_d;
  logic [15:0]       vec_count_q;
  logic [15:0]       vec_count_d;
  logic              in_ready_q;
  logic              start_q;
  logic              out_valid_q;
  logic              accept_s;
  logic              vec_end_s;
  logic              timeout_s;

`ifdef LOG_REG_FEEDER_TIMEOUT_EN
  log_reg_watchdog #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear_i  (state_q == S_FIRE),
    .count_i  (state_q == S_WAIT),
    .expired_o(timeout_s)
  );
`else
  // No watchdog: constant 0 for every legal limit, so WAIT waits indefinitely.
  assign timeout_s = (TIMEOUT_CYCLES < 0);
`endif

  assign accept_s  = (state_q == S_LOAD) && in_valid;
  assign vec_end_s = accept_s && (in_last || (idx_q == LAST_IDX));

  // Next-state and datapath update for the sequencer FSM.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    feat_d      = feat_q;
    data_d      = data_q;
    status_d    = status_q;
    vec_count_d = vec_count_q;
    case (state_q)
      S_IDLE: begin
        state_d = S_LOAD;
      end
      S_LOAD: begin
        if (accept_s) begin
          // Early in_last zero-fills the unwritten tail in the same cycle.
          for (int j = 0; j < NUM_FEATURES; j++) begin
            if (IDX_W'(j) == idx_q) begin
              feat_d[j] = in_data;
            end else if (vec_end_s && (IDX_W'(j) > idx_q)) begin
              feat_d[j] = '0;
            end else begin
              feat_d[j] = feat_q[j];
            end
          end
          if (vec_end_s) begin
            status_d[ST_SHORT] = (idx_q != LAST_IDX);
            state_d            = S_FIRE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          state_d = S_LOAD;
        end
      end
      S_FIRE: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (core_done) begin
          data_d               = core_prediction;
          status_d[ST_TIMEOUT] = 1'b0;
          state_d              = S_HOLD;
        end else if (timeout_s) begin
          data_d               = '0;
          status_d[ST_TIMEOUT] = 1'b1;
          state_d              = S_HOLD;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          vec_count_d = vec_count_q + 16'd1;
          idx_d       = '0;
          status_d    = 2'b00;
          state_d     = S_LOAD;
        end else begin
          state_d = S_HOLD;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, datapath and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      feat_q      <= '{default: '0};
      data_q      <= '0;
      status_q    <= 2'b00;
      vec_count_q <= 16'd0;
      in_ready_q  <= 1'b0;
      start_q     <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      feat_q      <= feat_d;
      data_q      <= data_d;
      status_q    <= status_d;
      vec_count_q <= vec_count_d;
      in_ready_q  <= (state_d == S_LOAD);
      start_q     <= (state_d == S_FIRE);
      out_valid_q <= (state_d == S_HOLD);
    end
  end

  assign in_ready   = in_ready_q;
  assign start      = start_q;
  assign out_valid  = out_valid_q;
  assign out_data   = data_q;
  assign out_status = status_q;
  assign vec_count  = vec_count_q;
  assign features   = feat_q;

endmodule

// File: tb/tb_log_reg_feeder.sv
// Randomized self-checking bench for log_reg_feeder: stub core plus a transaction-level reference model.
module tb_log_reg_feeder;

  localparam int N  = 4;
  localparam int TO = 8;

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b0;
  logic        in_valid  = 1'b0;
  logic        in_last   = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_data   = 32'h0;
  logic        in_ready;
  logic        start;
  logic        out_valid;
  logic [31:0] features [N];
  logic [31:0] core_prediction;
  logic [31:0] out_data;
  logic        core_done;
  logic        stub_done = 1'b0;
  logic        spur_done = 1'b0;
  logic [1:0]  out_status;
  logic [15:0] vec_count;

  logic        stub_en   = 1'b1;
  int          stub_lat  = 3;
  logic [31:0] stub_pred = 32'h0;

  int          n_checks  = 0;
  int          n_errors  = 0;
  logic [15:0] exp_count = 16'd0;
  logic [31:0] exp_data  = 32'h0;
  logic [1:0]  exp_status = 2'b00;
  logic [31:0] words [N];

  assign core_done = stub_done | spur_done;

  always #5 clk = ~clk;

  log_reg_feeder #(
    .NUM_FEATURES  (N),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .in_last        (in_last),
    .start          (start),
    .features       (features),
    .core_prediction(core_prediction),
    .core_done      (core_done),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_status     (out_status),
    .vec_count      (vec_count)
  );

  // Stub core: answers stub_lat cycles after the start pulse, junk on the result bus otherwise.
  initial begin : core_stub
    core_prediction = 32'h0;
    forever begin
      @(negedge clk);
      stub_done       = 1'b0;
      core_prediction = $urandom;
      if (start === 1'b1 && stub_en) begin
        repeat (stub_lat) begin
          @(negedge clk);
          core_prediction = $urandom;
        end
        stub_done       = 1'b1;
        core_prediction = stub_pred;
      end
    end
  end

  initial begin : global_limit
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench stopped by time limit");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs();
    check_eq("rst_in_ready", 32'(in_ready), 32'd0);
    check_eq("rst_start", 32'(start), 32'd0);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out_data", out_data, 32'd0);
    check_eq("rst_out_status", 32'(out_status), 32'd0);
    check_eq("rst_vec_count", 32'(vec_count), 32'd0);
    for (int j = 0; j < N; j++) check_eq("rst_features", features[j], 32'd0);
  endtask

  task automatic random_words();
    for (int i = 0; i < N; i++) words[i] = $urandom;
  endtask

  // Loads words[0..len-1]; returns at the first WAIT cycle.
  task automatic load_vector(input int len, input bit use_last, input bit spur);
    int cyc;
    cyc = 0;
    while (in_ready !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("in_ready_load", 32'(in_ready), 32'd1);
    for (int i = 0; i < len; i++) begin
      int gap;
      gap       = $urandom_range(0, 1);
      spur_done = spur;
      repeat (gap) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
      in_valid = 1'b1;
      in_data  = words[i];
      in_last  = use_last && (i == len - 1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = $urandom;
    check_eq("start_pulse", 32'(start), 32'd1);
    check_eq("in_ready_fire", 32'(in_ready), 32'd0);
    check_eq("out_data_kept", out_data, exp_data);
    check_eq("out_valid_fire", 32'(out_valid), 32'd0);
    @(negedge clk);
    spur_done = 1'b0;
    check_eq("start_one_cycle", 32'(start), 32'd0);
    for (int j = 0; j < N; j++)
      check_eq("features", features[j], (j < len) ? words[j] : 32'd0);
  endtask

  task automatic hold_handshake(input int bp);
    repeat (bp) begin
      @(negedge clk);
      check_eq("bp_out_valid", 32'(out_valid), 32'd1);
      check_eq("bp_out_data", out_data, exp_data);
      check_eq("bp_out_status", 32'(out_status), 32'(exp_status));
      check_eq("bp_in_ready", 32'(in_ready), 32'd0);
      check_eq("bp_vec_count", 32'(vec_count), 32'(exp_count));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    exp_count = exp_count + 16'd1;
    check_eq("hs_out_valid", 32'(out_valid), 32'd0);
    check_eq("hs_in_ready", 32'(in_ready), 32'd1);
    check_eq("hs_vec_count", 32'(vec_count), 32'(exp_count));
    check_eq("hs_out_status", 32'(out_status), 32'd0);
  endtask

  task automatic run_vector(input int len, input bit use_last, input int lat,
                            input logic [31:0] pred, input int bp, input bit spur);
    int cyc;
    stub_lat  = lat;
    stub_pred = pred;
    load_vector(len, use_last, spur);
    cyc = 1;
    while (out_valid !== 1'b1 && cyc < lat + 10) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("done_to_valid", 32'(cyc), 32'(lat + 1));
    exp_data   = pred;
    exp_status = {1'b0, (len < N)};
    check_eq("out_data", out_data, exp_data);
    check_eq("out_status", 32'(out_status), 32'(exp_status));
    check_eq("hold_in_ready", 32'(in_ready), 32'd0);
    hold_handshake(bp);
  endtask

  initial begin : main
    int cyc;
    repeat (2) @(negedge clk);
    check_reset_outputs();
    rst_n = 1'b1;
    check_eq("idle_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    check_eq("load_in_ready", 32'(in_ready), 32'd1);

    // Full vector 1,2,3,4 with in_last on the final word.
    for (int i = 0; i < N; i++) words[i] = 32'(i + 1);
    run_vector(N, 1'b1, 3, 32'h0000_00AA, 0, 1'b0);

    // Short vector 7,9 with backpressure and spurious done pulses.
    words[0] = 32'd7;
    words[1] = 32'd9;
    run_vector(2, 1'b1, $urandom_range(1, 6), $urandom, 5, 1'b1);

    for (int v = 0; v < 20; v++) begin
      int len;
      bit ul;
      len = $urandom_range(1, N);
      ul  = (len < N) ? 1'b1 : 1'(($urandom_range(0, 1)));
      random_words();
      run_vector(len, ul, $urandom_range(1, 6), $urandom, $urandom_range(0, 3),
                 1'($urandom_range(0, 1)));
    end

    // Core never answers.
    stub_en = 1'b0;
    random_words();
    load_vector(N, 1'b1, 1'b0);
`ifdef LOG_REG_FEEDER_TIMEOUT_EN
    cyc = 1;
    while (out_valid !== 1'b1 && cyc < TO + 10) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("timeout_latency", 32'(cyc), 32'(TO + 1));
    exp_data   = 32'h0;
    exp_status = 2'b10;
    check_eq("timeout_data", out_data, exp_data);
    check_eq("timeout_status", 32'(out_status), 32'(exp_status));
    hold_handshake(0);
    random_words();
    load_vector(2, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
`else
    cyc = 0;
    repeat (100) @(negedge clk);
    check_eq("stuck_out_valid", 32'(out_valid), 32'd0);
    check_eq("stuck_in_ready", 32'(in_ready), 32'd0);
    check_eq("stuck_start", 32'(start), 32'd0);
`endif

    // Asynchronous reset in the middle of WAIT.
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    exp_count  = 16'd0;
    exp_data   = 32'h0;
    exp_status = 2'b00;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_eq("rel_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    check_eq("rel_load_in_ready", 32'(in_ready), 32'd1);
    stub_en = 1'b1;
    random_words();
    run_vector(3, 1'b1, 2, $urandom, 0, 1'b0);

    // Preload the completion counter to its top value, then complete one more vector.
    force dut.vec_count_q = 16'hFFFF;
    @(negedge clk);
    release dut.vec_count_q;
    @(negedge clk);
    exp_count = 16'hFFFF;
    check_eq("vec_count_preload", 32'(vec_count), 32'(exp_count));
    random_words();
    run_vector(N, 1'b0, 1, $urandom, 1, 1'b0);
    check_eq("vec_count_wrap", 32'(vec_count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
